// File: rtl/seven_display_mux.sv
// Time-multiplexed common-anode 7-segment driver with hex decode, decimal points, per-digit enables
// and leading-zero suppression. Optional blinking is enabled by defining SEVEN_DISPLAY_MUX_BLINK_EN.
module seven_display_mux #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 100000,
   parameter bit HEX_EN      = 1'b1
`ifdef SEVEN_DISPLAY_MUX_BLINK_EN
   , parameter int BLINK_DIV = 50000000
`endif
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic [4*NUM_DIGITS-1:0] digits_i,
   input  logic [NUM_DIGITS-1:0]   dp_i,
   input  logic [NUM_DIGITS-1:0]   digit_en_i,
   input  logic                    lz_en_i,
`ifdef SEVEN_DISPLAY_MUX_BLINK_EN
   input  logic [NUM_DIGITS-1:0]   blink_mask_i,
`endif
   output logic [7:0]              seg_o,
   output logic [NUM_DIGITS-1:0]   an_o
);

   localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int PTR_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_DIGITS - 1);

   logic [DIV_W-1:0]      div_q, div_d;
   logic [PTR_W-1:0]      ptr_q, ptr_d;
   logic [7:0]            seg_q, seg_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic                  tick;
   logic [NUM_DIGITS-1:0] supp;
   logic                  all_zero;
   logic [3:0]            cur_val;
   logic                  cur_dp, cur_en, cur_supp, cur_blink;
   logic                  blink_dark;
   logic                  dark;
   logic [NUM_DIGITS-1:0] an_lit;

   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
         4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
         4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
         4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
      endcase
      if (!HEX_EN && (v >= 4'hA)) s = 7'h7F;
      return s;
   endfunction

   // A digit is suppressed only when it and everything above it is zero; digit 0 always shows.
   always_comb begin
      supp     = '0;
      all_zero = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         all_zero = all_zero & (digits_i[4*i +: 4] == 4'h0);
         supp[i]  = lz_en_i & all_zero;
      end
   end

   always_comb begin
      cur_val   = 4'h0;
      cur_dp    = 1'b0;
      cur_en    = 1'b0;
      cur_supp  = 1'b0;
      cur_blink = 1'b0;
      an_lit    = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (ptr_q == PTR_W'(i)) begin
            cur_val  = digits_i[4*i +: 4];
            cur_dp   = dp_i[i];
            cur_en   = digit_en_i[i];
            cur_supp = supp[i];
`ifdef SEVEN_DISPLAY_MUX_BLINK_EN
            cur_blink = blink_mask_i[i];
`endif
            an_lit[i] = 1'b0;
         end
      end
   end

`ifdef SEVEN_DISPLAY_MUX_BLINK_EN
   localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

   logic [BLK_W-1:0] blink_cnt_q;
   logic             blink_phase_q;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
      end else if (blink_cnt_q == BLK_LAST) begin
         blink_cnt_q   <= '0;
         blink_phase_q <= ~blink_phase_q;
      end else begin
         blink_cnt_q   <= blink_cnt_q + BLK_W'(1);
      end
   end

   assign blink_dark = blink_phase_q & cur_blink;
`else
   assign blink_dark = 1'b0 & cur_blink;
`endif

   always_comb begin
      tick  = (div_q == DIV_LAST);
      div_d = tick ? '0 : div_q + DIV_W'(1);
      ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
      dark  = ~cur_en | cur_supp | blink_dark;
      seg_d = dark ? 8'hFF : {~cur_dp, decode(cur_val)};
      an_d  = dark ? '1 : an_lit;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         div_q <= '0;
         ptr_q <= '0;
         seg_q <= 8'hFF;
         an_q  <= '1;
      end else begin
         div_q <= div_d;
         if (tick) begin
            ptr_q <= ptr_d;
            seg_q <= seg_d;
            an_q  <= an_d;
         end
      end
   end

   assign seg_o = seg_q;
   assign an_o  = an_q;

endmodule

// File: tb/tb_seven_display_mux.sv
// Directed bench for seven_display_mux: 4 digits, 4-cycle slots, one hex and one non-hex instance.
// Blink checks are compiled in when SEVEN_DISPLAY_MUX_BLINK_EN is defined.
module tb_seven_display_mux;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] digits = 16'h0;
   logic [3:0]  dp = 4'h0;
   logic [3:0]  digit_en = 4'hF;
   logic        lz_en = 1'b0;
   logic [7:0]  seg_h, seg_n;
   logic [3:0]  an_h, an_n;
`ifdef SEVEN_DISPLAY_MUX_BLINK_EN
   logic [3:0]  blink_mask = 4'h0;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seven_display_mux #(.NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_EN(1'b1)
`ifdef SEVEN_DISPLAY_MUX_BLINK_EN
      , .BLINK_DIV(32)
`endif
   ) u_hex (
      .clk_i(clk), .rst_n_i(rst_n), .digits_i(digits), .dp_i(dp),
      .digit_en_i(digit_en), .lz_en_i(lz_en),
`ifdef SEVEN_DISPLAY_MUX_BLINK_EN
      .blink_mask_i(blink_mask),
`endif
      .seg_o(seg_h), .an_o(an_h));

   seven_display_mux #(.NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_EN(1'b0)
`ifdef SEVEN_DISPLAY_MUX_BLINK_EN
      , .BLINK_DIV(32)
`endif
   ) u_nohex (
      .clk_i(clk), .rst_n_i(rst_n), .digits_i(digits), .dp_i(dp),
      .digit_en_i(digit_en), .lz_en_i(lz_en),
`ifdef SEVEN_DISPLAY_MUX_BLINK_EN
      .blink_mask_i(blink_mask),
`endif
      .seg_o(seg_n), .an_o(an_n));

   // Returns at a falling edge with zero rising edges seen since rst_n went high.
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      digits = 16'h1234; dp = 4'h0; digit_en = 4'hF; lz_en = 1'b0;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         checks++;
         if ({an_h, seg_h} !== 12'hFFF) begin
            $display("FAIL reset_dark cycle %0d: got an=%h seg=%h, expected an=f seg=ff", k, an_h, seg_h);
            errors++;
         end
         @(negedge clk);
      end
   endtask

   // Picks up right after the first slot-0 load left by test_reset.
   task automatic test_scan();
      logic [11:0] exp [4];
      exp = '{12'hE99, 12'hDB0, 12'hBA4, 12'h7F9};
      for (int s = 0; s < 8; s++) begin
         checks++;
         if ({an_h, seg_h} !== exp[s%4]) begin
            $display("FAIL scan slot %0d: got an=%h seg=%h, expected %h", s, an_h, seg_h, exp[s%4]);
            errors++;
         end
         if (s == 0) begin
            @(negedge clk);
            checks++;
            if ({an_h, seg_h} !== exp[0]) begin
               $display("FAIL scan_hold: got an=%h seg=%h, expected %h", an_h, seg_h, exp[0]);
               errors++;
            end
            repeat (3) @(negedge clk);
         end else begin
            repeat (4) @(negedge clk);
         end
      end
   endtask

   task automatic test_hex();
      logic [11:0] exp_h [4];
      logic [11:0] exp_n [4];
      exp_h = '{12'hEA1, 12'hDC6, 12'hB83, 12'h788};
      exp_n = '{12'hEFF, 12'hDFF, 12'hBFF, 12'h7FF};
      digits = 16'hABCD; dp = 4'h0; digit_en = 4'hF; lz_en = 1'b0;
      do_reset();
      repeat (4) @(negedge clk);
      for (int s = 0; s < 4; s++) begin
         checks++;
         if ({an_h, seg_h} !== exp_h[s]) begin
            $display("FAIL hex slot %0d: got an=%h seg=%h, expected %h", s, an_h, seg_h, exp_h[s]);
            errors++;
         end
         checks++;
         if ({an_n, seg_n} !== exp_n[s]) begin
            $display("FAIL nohex slot %0d: got an=%h seg=%h, expected %h", s, an_n, seg_n, exp_n[s]);
            errors++;
         end
         repeat (4) @(negedge clk);
      end
   endtask

   task automatic test_lz();
      logic [11:0] exp [3][4];
      logic [15:0] dig [3];
      logic        lz [3];
      exp = '{'{12'hEC0, 12'hD92, 12'hFFF, 12'hFFF},
              '{12'hEC0, 12'hD92, 12'hBC0, 12'h7C0},
              '{12'hEC0, 12'hFFF, 12'hFFF, 12'hFFF}};
      dig = '{16'h0050, 16'h0050, 16'h0000};
      lz  = '{1'b1, 1'b0, 1'b1};
      for (int c = 0; c < 3; c++) begin
         digits = dig[c]; dp = 4'h0; digit_en = 4'hF; lz_en = lz[c];
         do_reset();
         repeat (4) @(negedge clk);
         for (int s = 0; s < 4; s++) begin
            checks++;
            if ({an_h, seg_h} !== exp[c][s]) begin
               $display("FAIL lz case %0d slot %0d: got an=%h seg=%h, expected %h", c, s, an_h, seg_h, exp[c][s]);
               errors++;
            end
            repeat (4) @(negedge clk);
         end
      end
   endtask

   task automatic test_dp_enable();
      logic [11:0] exp [2][4];
      logic [15:0] dig [2];
      logic [3:0]  dpv [2];
      logic [3:0]  env [2];
      exp = '{'{12'hE80, 12'hD80, 12'hFFF, 12'h780},
              '{12'hE19, 12'hD30, 12'hBA4, 12'h7F9}};
      dig = '{16'h8888, 16'h1234};
      dpv = '{4'b0100, 4'b0011};
      env = '{4'b1011, 4'b1111};
      for (int c = 0; c < 2; c++) begin
         digits = dig[c]; dp = dpv[c]; digit_en = env[c]; lz_en = 1'b0;
         do_reset();
         repeat (4) @(negedge clk);
         for (int s = 0; s < 4; s++) begin
            checks++;
            if ({an_h, seg_h} !== exp[c][s]) begin
               $display("FAIL dp_en case %0d slot %0d: got an=%h seg=%h, expected %h", c, s, an_h, seg_h, exp[c][s]);
               errors++;
            end
            repeat (4) @(negedge clk);
         end
      end
      dp = 4'h0; digit_en = 4'hF;
   endtask

   // Inputs changed mid-slot must not show until the next slot loads.
   task automatic test_back_to_back();
      digits = 16'h1234; dp = 4'h0; digit_en = 4'hF; lz_en = 1'b0;
      do_reset();
      repeat (4) @(negedge clk);
      repeat (2) @(negedge clk);
      digits = 16'h0000;
      @(negedge clk);
      checks++;
      if ({an_h, seg_h} !== 12'hE99) begin
         $display("FAIL b2b_hold: got an=%h seg=%h, expected e99", an_h, seg_h);
         errors++;
      end
      @(negedge clk);
      checks++;
      if ({an_h, seg_h} !== 12'hDC0) begin
         $display("FAIL b2b_next: got an=%h seg=%h, expected dc0", an_h, seg_h);
         errors++;
      end
   endtask

   task automatic test_mid_reset();
      digits = 16'h1234; dp = 4'h0; digit_en = 4'hF; lz_en = 1'b0;
      do_reset();
      repeat (12) @(negedge clk);
      checks++;
      if ({an_h, seg_h} !== 12'hBA4) begin
         $display("FAIL midrst_pre: got an=%h seg=%h, expected ba4", an_h, seg_h);
         errors++;
      end
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checks++;
      if ({an_h, seg_h} !== 12'hFFF) begin
         $display("FAIL midrst_dark: got an=%h seg=%h, expected fff", an_h, seg_h);
         errors++;
      end
      repeat (3) @(negedge clk);
      checks++;
      if ({an_h, seg_h} !== 12'hFFF) begin
         $display("FAIL midrst_wait: got an=%h seg=%h, expected fff", an_h, seg_h);
         errors++;
      end
      @(negedge clk);
      checks++;
      if ({an_h, seg_h} !== 12'hE99) begin
         $display("FAIL midrst_restart: got an=%h seg=%h, expected e99", an_h, seg_h);
         errors++;
      end
   endtask

`ifdef SEVEN_DISPLAY_MUX_BLINK_EN
   // Slot 0 loads at edges 4+16f; phase is 1 for edges 32..63, so frames 2 and 3 are dark.
   task automatic test_blink();
      logic [11:0] exp0 [6];
      exp0 = '{12'hE99, 12'hE99, 12'hFFF, 12'hFFF, 12'hE99, 12'hE99};
      digits = 16'h1234; dp = 4'h0; digit_en = 4'hF; lz_en = 1'b0;
      blink_mask = 4'b0001;
      do_reset();
      repeat (4) @(negedge clk);
      for (int f = 0; f < 6; f++) begin
         checks++;
         if ({an_h, seg_h} !== exp0[f]) begin
            $display("FAIL blink frame %0d slot0: got an=%h seg=%h, expected %h", f, an_h, seg_h, exp0[f]);
            errors++;
         end
         repeat (4) @(negedge clk);
         checks++;
         if ({an_h, seg_h} !== 12'hDB0) begin
            $display("FAIL blink frame %0d slot1: got an=%h seg=%h, expected db0", f, an_h, seg_h);
            errors++;
         end
         repeat (12) @(negedge clk);
      end
      blink_mask = 4'h0;
   endtask
`endif

   initial begin
      test_reset();
      test_scan();
      test_hex();
      test_lz();
      test_dp_enable();
      test_back_to_back();
      test_mid_reset();
`ifdef SEVEN_DISPLAY_MUX_BLINK_EN
      test_blink();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
